// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end with credit-based pipelined imem requests,
// an in-order response FIFO feeding IF/ID, stall handling and redirect squash.
module if_prefetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [31:0] out_instr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pc_q    [DEPTH];
  logic [31:0]   r_instr_q [DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_outstanding, r_drop_cnt;
  logic          w_credit, w_accept, w_push, w_pop;
  logic [31:0]   w_tag_pc;

  assign w_credit       = (int'(r_outstanding) < MAX_OUTSTANDING) &&
                          (int'(r_count) + int'(r_outstanding) < DEPTH);
  assign imem_req_valid = rst && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_push         = imem_resp_valid && r_drop_cnt == '0 && !redirect_valid;
  assign out_valid      = rst && r_count != '0 && !redirect_valid;
  assign w_pop          = out_valid && !stall;
  // Kept responses belong to contiguous words ending at fetch_pc-4, so the oldest tag is derived, not stored.
  assign w_tag_pc       = r_fetch_pc - (32'(r_outstanding) << 2);
  assign out_pc         = r_pc_q[r_rd_ptr];
  assign out_instr      = r_instr_q[r_rd_ptr];
  assign out_pc4        = out_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + OW'(w_accept) - OW'(imem_resp_valid);
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & ~32'd3;
        r_rd_ptr   <= r_wr_ptr;
        r_count    <= '0;
        r_drop_cnt <= r_outstanding - OW'(imem_resp_valid);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (imem_resp_valid && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - OW'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]    <= w_tag_pc;
      r_instr_q[r_wr_ptr] <= imem_resp_data;
    end
    if (rst) begin
      assert (!(imem_resp_valid && r_outstanding == '0));
      assert (!(w_push && r_count == CW'(DEPTH)));
    end
  end
endmodule
